// File: rtl/apb_initiator.sv
// APB4 initiator: turns a valid/ready request stream into single outstanding APB
// transfers and returns each completion on a valid/ready response channel.
module apb_initiator #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned WAIT_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic                  req_write,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   input  logic                  pready,
   output logic [ADDR_W-1:0]     paddr,
   output logic                  pwrite,
   output logic [31:0]           pwdata,
   output logic [3:0]            pwstrb,
   input  logic [31:0]           prdata,
   input  logic                  pslverr,
   output logic [WAIT_CNT_W-1:0] wait_cnt
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_rsp_valid;
   logic [ADDR_W-1:0]     r_paddr;
   logic                  r_pwrite;
   logic [31:0]           r_pwdata;
   logic [3:0]            r_pwstrb;
   logic [31:0]           r_rsp_rdata;
   logic                  r_rsp_err;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_stall;

   assign w_accept = (r_state == IDLE) && req_valid;
   assign w_done   = (r_state == ACCESS) && pready;
   assign w_stall  = (r_state == ACCESS) && !pready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_valid) w_next = SETUP;
         SETUP:   w_next = ACCESS;
         ACCESS:  if (pready) w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // APB control and rsp_valid are registered from the next state so they
   // change on the same edge as the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_psel      <= (w_next == SETUP) || (w_next == ACCESS);
         r_penable   <= (w_next == ACCESS);
         r_rsp_valid <= (w_next == RESP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_pwstrb    <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_wait_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_pwstrb <= req_write ? req_wstrb : 4'b0000;
         end
         if (w_done) begin
            r_rsp_rdata <= r_pwrite ? 32'h0 : prdata;
            r_rsp_err   <= pslverr;
         end
         if (w_stall && (r_wait_cnt != '1)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign paddr     = r_paddr;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;
   assign pwstrb    = r_pwstrb;
   assign wait_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_apb_initiator;

   localparam int unsigned AW   = 32;
   localparam int unsigned WCW  = 4;
   localparam int          WMAX = (1 << WCW) - 1;

   logic           clk;
   logic           rst_n;
   logic           req_valid;
   logic           req_ready;
   logic [AW-1:0]  req_addr;
   logic           req_write;
   logic [31:0]    req_wdata;
   logic [3:0]     req_wstrb;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [31:0]    rsp_rdata;
   logic           rsp_err;
   logic           psel;
   logic           penable;
   logic           pready;
   logic [AW-1:0]  paddr;
   logic           pwrite;
   logic [31:0]    pwdata;
   logic [3:0]     pwstrb;
   logic [31:0]    prdata;
   logic           pslverr;
   logic [WCW-1:0] wait_cnt;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   apb_initiator #(.ADDR_W(AW), .WAIT_CNT_W(WCW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .psel(psel), .penable(penable), .pready(pready),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
      .prdata(prdata), .pslverr(pslverr), .wait_cnt(wait_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transfer, tracked by its age in
   // cycles since acceptance and whether the target has completed it.
   bit          m_active;
   int          m_age;
   bit          m_resp;
   logic [31:0] m_addr;
   bit          m_write;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] m_rdata;
   bit          m_err;
   int          m_wait;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 0; m_age <= 0; m_resp <= 0; m_wait <= 0;
         m_addr <= '0; m_write <= 0; m_wdata <= '0; m_wstrb <= '0;
         m_rdata <= '0; m_err <= 0;
      end else if (!m_active) begin
         if (req_valid) begin
            m_active <= 1; m_age <= 1; m_resp <= 0;
            m_addr <= req_addr; m_write <= req_write; m_wdata <= req_wdata;
            m_wstrb <= req_write ? req_wstrb : 4'b0000;
         end
      end else if (!m_resp) begin
         if (m_age >= 2 && pready) begin
            m_resp  <= 1;
            m_rdata <= m_write ? 32'h0 : prdata;
            m_err   <= pslverr;
         end else begin
            m_age <= m_age + 1;
            if (m_age >= 2) m_wait <= (m_wait >= WMAX) ? WMAX : m_wait + 1;
         end
      end else if (rsp_ready) begin
         m_active <= 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", req_ready, !m_active);
         check("psel",      psel,      m_active && !m_resp);
         check("penable",   penable,   m_active && !m_resp && m_age >= 2);
         check("rsp_valid", rsp_valid, m_active && m_resp);
         check("wait_cnt",  wait_cnt,  m_wait);
         if (m_active && !m_resp) begin
            check("paddr",  paddr,  m_addr);
            check("pwrite", pwrite, m_write);
            check("pwdata", pwdata, m_wdata);
            check("pwstrb", pwstrb, m_wstrb);
         end
         if (m_active && m_resp) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err",   rsp_err,   m_err);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request, waits (bounded) for acceptance; returns in SETUP cycle.
   task automatic start_req(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s);
      req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
      for (int n = 0; !req_ready && n < 20; n++) tick();
      check("accept_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
   endtask

   // From SETUP: runs ACCESS with nw wait states; returns in first RESP cycle.
   task automatic access(input int nw, input logic [31:0] rd, input bit er);
      tick();
      for (int i = 0; i < nw; i++) begin
         pready = 1'b0; prdata = 32'hBADC0DE0 + i; pslverr = 1'b1;
         tick();
      end
      pready = 1'b1; prdata = rd; pslverr = er;
      tick();
      pready = 1'b0; prdata = 32'hA5A55A5A; pslverr = 1'b1;
   endtask

   task automatic finish_rsp(input int hold);
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 1'b0; req_valid = 0; req_addr = '0; req_write = 0; req_wdata = '0;
      req_wstrb = '0; rsp_ready = 0; pready = 0; prdata = '0; pslverr = 0;
      #12;
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_wait_cnt", wait_cnt, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_pwstrb", pwstrb, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_req_ready", req_ready, 1);
      chk_en = 1;
      @(posedge clk); #3 rst_n = 1'b1;
      tick();

      // 1: zero-wait read, 3-cycle latency
      start_req(32'h0000_0100, 0, 32'h1111_2222, 4'hF);
      check("t1_setup_psel", psel, 1);
      check("t1_setup_penable", penable, 0);
      check("t1_setup_pwstrb", pwstrb, 0);
      tick();
      check("t1_access_penable", penable, 1);
      pready = 1'b1; prdata = 32'hDEADBEEF; pslverr = 1'b0;
      tick();
      pready = 1'b0; prdata = 32'h0;
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("t1_rsp_err", rsp_err, 0);
      check("t1_psel_off", psel, 0);
      finish_rsp(0);

      // 2: write with 3 wait states
      start_req(32'h8000_0004, 1, 32'h0000_0055, 4'b0001);
      access(3, 32'hFFFF_FFFF, 0);
      check("t2_rsp_rdata", rsp_rdata, 0);
      check("t2_wait_cnt", wait_cnt, 3);
      finish_rsp(1);

      // 3: decode error
      start_req(32'hA000_0000, 0, 32'h0, 4'h0);
      access(0, 32'h0, 1);
      check("t3_rsp_err", rsp_err, 1);
      check("t3_rsp_rdata", rsp_rdata, 0);
      finish_rsp(0);
      check("t3_idle_ready", req_ready, 1);

      // 4: response back-pressure with next request already waiting
      start_req(32'h0000_0200, 0, 32'h0, 4'h0);
      req_addr = 32'h1000_0008; req_write = 1; req_wdata = 32'hCAFEF00D;
      req_wstrb = 4'b1100; req_valid = 1'b1;
      access(0, 32'h1234_5678, 0);
      held = rsp_rdata;
      for (int i = 0; i < 5; i++) begin
         rsp_ready = 1'b0;
         check("t4_hold_rdata", rsp_rdata, 32'h1234_5678);
         check("t4_hold_ready", req_ready, 0);
         check("t4_hold_psel", psel, 0);
         tick();
      end
      check("t4_rdata_stable", rsp_rdata, held);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t4_post_hs_ready", req_ready, 1);
      check("t4_post_hs_psel", psel, 0);
      tick();
      req_valid = 1'b0;
      check("t4_setup_psel", psel, 1);
      check("t4_setup_paddr", paddr, 32'h1000_0008);
      check("t4_setup_pwstrb", pwstrb, 4'b1100);
      access(1, 32'h0, 0);
      check("t4_wr_rdata", rsp_rdata, 0);
      finish_rsp(0);

      // 5: async reset during stalled ACCESS
      start_req(32'h0000_0040, 0, 32'h0, 4'h0);
      pready = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("t5_psel_async", psel, 0);
      check("t5_penable_async", penable, 0);
      check("t5_ready_async", req_ready, 1);
      @(posedge clk); #3 rst_n = 1'b1;
      tick();
      check("t5_ready", req_ready, 1);
      check("t5_rsp_valid", rsp_valid, 0);
      check("t5_wait_cnt", wait_cnt, 0);

      // 6: wait counter saturation
      start_req(32'h0000_0080, 0, 32'h0, 4'h0);
      access((1 << WCW) + 2, 32'h0000_00AA, 0);
      check("t6_wait_sat", wait_cnt, 4'hF);
      check("t6_rsp_rdata", rsp_rdata, 32'h0000_00AA);
      finish_rsp(2);
      tick();

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
